// File: rtl/la_xorn_pkg.sv
// Shared types and default sizing for the registered N-input XOR block.
package la_xorn_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int DW_DEF = 8;
    localparam int N_DEF  = 4;
    localparam int CW_DEF = 16;
endpackage

// File: rtl/la_xorn_tree.sv
// Combinational XOR reduction of N packed DW-bit words down to one word.
module la_xorn_tree #(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic [N*DW-1:0] data,
    output logic [DW-1:0]   r
);
    logic [N:0][DW-1:0] part;

    assign part[0] = '0;
    for (genvar k = 0; k < N; k++) begin : g_fold
        assign part[k+1] = part[k] ^ data[k*DW +: DW];
    end
    assign r = part[N];
endmodule

// File: rtl/la_xorn.sv
// Registered N-input XOR with valid/ready handshake and packet accumulate mode.
// Define LA_XORN_PARITY_EN to register a reduction-XOR parity bit with out_data.
module la_xorn
    import la_xorn_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int N    = N_DEF,
    parameter int CW   = CW_DEF,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_beats,
    output logic          out_parity
);
    state_t        state;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [DW-1:0] r;
    logic [DW-1:0] res;
    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic          load;

    la_xorn_tree #(.DW(DW), .N(N)) u_tree (
        .data (in_data),
        .r    (r)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Beat count sticks at all-ones; the data fold itself never saturates.
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    assign res      = (state == ACCUM) ? (acc ^ r) : r;
    assign load     = accept && ((state == ACCUM) ? in_last : (!mode || in_last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!mode || in_last) begin
                            out_data  <= r;
                            out_beats <= CW'(1);
                            out_valid <= 1'b1;
                        end else begin
                            acc   <= r;
                            cnt   <= CW'(1);
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (in_last) begin
                            out_data  <= acc ^ r;
                            out_beats <= cnt_inc;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            acc <= acc ^ r;
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LA_XORN_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_parity <= 1'b0;
        else if (load)
            out_parity <= ^res;
    end
`else
    assign out_parity = 1'b0;
`endif
endmodule

// File: tb/tb_la_xorn.sv
// Directed self-checking bench for la_xorn (default sizing plus a CW=2 instance).
module tb_la_xorn;
    localparam int DW = 8;
    localparam int N  = 4;
`ifdef LA_XORN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic [N*DW-1:0] in_data = '0;

    logic          in_ready, out_valid, out_parity;
    logic [DW-1:0] out_data;
    logic [15:0]   out_beats;
    logic          in_ready2, out_valid2, out_parity2;
    logic [DW-1:0] out_data2;
    logic [1:0]    out_beats2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    la_xorn #(.DW(DW), .N(N), .CW(16)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_beats(out_beats), .out_parity(out_parity)
    );

    la_xorn #(.DW(DW), .N(N), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_beats(out_beats2), .out_parity(out_parity2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack(input logic [7:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic last, input logic [7:0] rv);
        mode     = m;
        in_last  = last;
        in_valid = 1'b1;
        in_data  = pack(rv, 8'h00, 8'h00, 8'h00);
        tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_beats", out_beats, 0);
        check("rst_parity", out_parity, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_in_ready2", in_ready2, 1);
        reset = 1'b0;

        // Word mode, two back-to-back beats
        mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = pack(8'h0F, 8'hF0, 8'h55, 8'hAA);
        tick();
        check("word1_valid", out_valid, 1);
        check("word1_data", out_data, 8'h00);
        check("word1_beats", out_beats, 1);
        in_data = pack(8'h01, 8'h02, 8'h04, 8'h08);
        tick();
        check("word2_valid", out_valid, 1);
        check("word2_data", out_data, 8'h0F);
        in_valid = 1'b0;
        tick();
        check("word_drain", out_valid, 0);

        // Accumulate 3 beats; mode flips mid-packet and must be ignored
        beat(1'b1, 1'b0, 8'h11);
        check("acc_b1_novalid", out_valid, 0);
        beat(1'b0, 1'b0, 8'h22);
        check("acc_b2_novalid", out_valid, 0);
        beat(1'b0, 1'b1, 8'h44);
        check("acc_valid", out_valid, 1);
        check("acc_data", out_data, 8'h77);
        check("acc_beats", out_beats, 3);
        // Single-beat packet proves IDLE with acc cleared
        beat(1'b1, 1'b1, 8'h05);
        check("acc_idle_data", out_data, 8'h05);
        check("acc_idle_beats", out_beats, 1);

        // Parity on word results
        beat(1'b0, 1'b0, 8'h07);
        check("par7_data", out_data, 8'h07);
        check("par7", out_parity, PAR_EN ? 1 : 0);
        beat(1'b0, 1'b0, 8'h03);
        check("par3_data", out_data, 8'h03);
        check("par3", out_parity, 0);
        in_valid = 1'b0;
        tick();

        // Backpressure then simultaneous accept and load
        out_ready = 1'b0;
        beat(1'b0, 1'b0, 8'h5A);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 8'h5A);
        in_data = pack(8'hC3, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 0);
            tick();
            check("bp_hold_data", out_data, 8'h5A);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_swap_valid", out_valid, 1);
        check("bp_swap_data", out_data, 8'hC3);
        in_valid = 1'b0;
        tick();
        check("bp_drain", out_valid, 0);

        // Reset in the middle of a packet
        beat(1'b1, 1'b0, 8'h12);
        beat(1'b1, 1'b0, 8'h34);
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_beats", out_beats, 0);
        check("mid_rst_parity", out_parity, 0);
        reset = 1'b0;
        tick();
        beat(1'b1, 1'b1, 8'h3C);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 8'h3C);
        check("post_rst_beats", out_beats, 1);

        // Six-beat packet: CW=2 instance saturates at 3, data stays exact
        beat(1'b1, 1'b0, 8'h01);
        beat(1'b1, 1'b0, 8'h02);
        beat(1'b1, 1'b0, 8'h04);
        beat(1'b1, 1'b0, 8'h08);
        beat(1'b1, 1'b0, 8'h10);
        check("sat_novalid", out_valid2, 0);
        beat(1'b1, 1'b1, 8'h20);
        check("sat_valid", out_valid2, 1);
        check("sat_data", out_data2, 8'h3F);
        check("sat_beats", out_beats2, 3);
        check("wide_beats", out_beats, 6);
        check("wide_data", out_data, 8'h3F);
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
